// File: rtl/mod_seq_pkg.sv
// Shared types for the MOD-counter phase sequencer: FSM states, table entry layout
// and the default geometry the top-level parameters start from.
package mod_seq_pkg;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_CNT_WIDTH  = 4;
    localparam int DEF_REP_WIDTH  = 4;
    localparam int PHASE_W        = $clog2(DEF_NUM_PHASES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } seq_state_t;

    // Entry fields: a zero mod stands for 2^CNT_WIDTH; rep R means R+1 wraps per phase
    typedef struct packed {
        logic [DEF_CNT_WIDTH-1:0] mod;
        logic [DEF_REP_WIDTH-1:0] rep;
    } phase_cfg_t;

endpackage

// File: rtl/mod_counter_core.sv
// Wrapping MOD counter: counts 0..M-1 while enabled, with a terminal-count flag.
// A MOD value of 0 wraps at 2^CNT_WIDTH because mod_val-1 underflows to all ones.
module mod_counter_core #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] mod_val,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tc
);

    assign tc = (count == mod_val - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= tc ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/mod_counter_sequencer.sv
// Phase sequencer: runs a table of (MOD, repeat) entries through a MOD counter.
// Optional pause support is compiled in with `define MOD_SEQ_PAUSE_EN.
module mod_counter_sequencer
    import mod_seq_pkg::*;
#(
    parameter int NUM_PHASES = 1 << PHASE_W,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int REP_WIDTH  = DEF_REP_WIDTH
) (
    input  logic                          Clk_In,
    input  logic                          Resetb_In,
    input  logic                          Cfg_Wr_En_In,
    input  logic [$clog2(NUM_PHASES)-1:0] Cfg_Addr_In,
    input  logic [CNT_WIDTH-1:0]          Cfg_MOD_In,
    input  logic [REP_WIDTH-1:0]          Cfg_Rep_In,
    input  logic                          Start_In,
    input  logic                          Stop_In,
    input  logic                          Loop_En_In,
    output logic [CNT_WIDTH-1:0]          Count_Out,
    output logic [$clog2(NUM_PHASES)-1:0] Phase_Out,
    output logic                          Phase_Done_Out,
    output logic                          Seq_Done_Out,
    output logic                          Busy_Out
);

    localparam int              PH_W       = $clog2(NUM_PHASES);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);

    seq_state_t           state, nxt;
    phase_cfg_t           tbl [NUM_PHASES];
    phase_cfg_t           act;
    logic [PH_W-1:0]      phase, phase_nx;
    logic [REP_WIDTH-1:0] rep_cnt;
    logic                 tc, phase_end, seq_end, cnt_clear, cnt_en;

    assign phase_nx  = phase + 1'b1;
    assign phase_end = (state == ST_RUN) && tc && (rep_cnt == act.rep);
    assign seq_end   = phase_end && (phase == LAST_PHASE);
    // The counter only advances when staying in RUN, so a pause freezes it on the stop cycle
    assign cnt_clear = (nxt == ST_IDLE);
    assign cnt_en    = (state == ST_RUN) && (nxt == ST_RUN);

    mod_counter_core #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .clk     (Clk_In),
        .rst_n   (Resetb_In),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .mod_val (act.mod),
        .count   (Count_Out),
        .tc      (tc)
    );

    always_ff @(posedge Clk_In or negedge Resetb_In) begin
        if (!Resetb_In)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:
                if (Start_In && !Stop_In)
                    nxt = ST_RUN;
            ST_RUN:
                if (Stop_In)
`ifdef MOD_SEQ_PAUSE_EN
                    nxt = ST_PAUSE;
`else
                    nxt = ST_IDLE;
`endif
                else if (seq_end && !Loop_En_In)
                    nxt = ST_IDLE;
            ST_PAUSE:
                if (Stop_In)
                    nxt = ST_IDLE;
                else if (Start_In)
                    nxt = ST_RUN;
            default:
                nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_In or negedge Resetb_In) begin
        if (!Resetb_In) begin
            for (int i = 0; i < NUM_PHASES; i++)
                tbl[i] <= '0;
            act     <= '0;
            phase   <= '0;
            rep_cnt <= '0;
        end else begin
            if (Cfg_Wr_En_In && state == ST_IDLE)
                tbl[Cfg_Addr_In] <= '{mod: Cfg_MOD_In, rep: Cfg_Rep_In};

            if (nxt == ST_IDLE) begin
                phase   <= '0;
                rep_cnt <= '0;
            end else if (state == ST_IDLE) begin
                phase   <= '0;
                rep_cnt <= '0;
                act     <= tbl[0];
            end else if (cnt_en) begin
                // phase_nx wraps to 0 after the last entry, which is the loop restart
                if (phase_end) begin
                    phase   <= phase_nx;
                    rep_cnt <= '0;
                    act     <= tbl[phase_nx];
                end else if (tc) begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

    assign Phase_Out      = phase;
    assign Phase_Done_Out = phase_end;
    assign Seq_Done_Out   = seq_end;
    assign Busy_Out       = (state != ST_IDLE);

endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Scoreboard bench for mod_counter_sequencer: stimulus queues expected busy-cycle outputs,
// a negedge monitor pops and compares them whenever Busy_Out is high.
module tb_mod_counter_sequencer;

    localparam int CW = 4;
    localparam int RW = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [PW-1:0] addr = '0;
    logic [CW-1:0] mod_v = '0;
    logic [RW-1:0] rep_v = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [CW-1:0] count;
    logic [PW-1:0] phase;
    logic          pd, sd, busy;

    typedef struct {
        int cnt;
        int ph;
        int pd;
        int sd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Hand-computed scenario table P0{3,0} P1{2,1} P2{1,2} P3{5,0}, busy cycles 1..15
    int s1_cnt [15] = '{0, 1, 2, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2, 3, 4};
    int s1_ph  [15] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3};
    int s1_pd  [15] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    mod_counter_sequencer #(
        .NUM_PHASES (4),
        .CNT_WIDTH  (CW),
        .REP_WIDTH  (RW)
    ) dut (
        .Clk_In         (clk),
        .Resetb_In      (rst_n),
        .Cfg_Wr_En_In   (wr_en),
        .Cfg_Addr_In    (addr),
        .Cfg_MOD_In     (mod_v),
        .Cfg_Rep_In     (rep_v),
        .Start_In       (start),
        .Stop_In        (stop),
        .Loop_En_In     (loop_en),
        .Count_Out      (count),
        .Phase_Out      (phase),
        .Phase_Done_Out (pd),
        .Seq_Done_Out   (sd),
        .Busy_Out       (busy)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            if (exp_q.size() == 0) begin
                chk("busy_without_expectation", int'(busy), 0);
            end else begin
                e = exp_q.pop_front();
                chk("count", int'(count), e.cnt);
                chk("phase", int'(phase), e.ph);
                chk("phase_done", int'(pd), e.pd);
                chk("seq_done", int'(sd), e.sd);
            end
        end else begin
            chk("idle_outputs", int'({count, phase, pd, sd}), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int p, input int d, input int s);
        exp_t e;
        e.cnt = c;
        e.ph  = p;
        e.pd  = d;
        e.sd  = s;
        exp_q.push_back(e);
    endtask

    task automatic push_s1(input int n);
        for (int i = 0; i < n; i++)
            push(s1_cnt[i], s1_ph[i], s1_pd[i], int'(i == 14));
    endtask

    task automatic push_mod0();
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                push(i, p, int'(i == 15), int'(p == 3 && i == 15));
    endtask

    task automatic wr(input int a, input int m, input int r);
        wr_en = 1'b1;
        addr  = PW'(a);
        mod_v = CW'(m);
        rep_v = RW'(r);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_s1();
        wr(0, 3, 0);
        wr(1, 2, 1);
        wr(2, 1, 2);
        wr(3, 5, 0);
    endtask

    task automatic start_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_phase"}, int'(phase), 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({pd, sd, count, phase}), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Plain run, no loop
        load_s1();
        push_s1(15);
        start_seq();
        drain(40);
        chk_idle("s1_end");

        // Zero modulus entries give 16 states per phase
        for (int i = 0; i < 4; i++)
            wr(i, 0, 0);
        push_mod0();
        start_seq();
        drain(80);
        chk_idle("mod0_end");

        // Start with Stop in the same cycle stays idle
        load_s1();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", int'(busy), 0);
        tick();
        chk("start_stop_busy2", int'(busy), 0);

        // Loop: second pass wraps back to phase 0, stop at its last cycle
        loop_en = 1'b1;
        push_s1(15);
        push_s1(15);
        start_seq();
        repeat (29) tick();
        stop = 1'b1;
        tick();
        stop    = 1'b0;
        loop_en = 1'b0;
        chk("loop_queue", exp_q.size(), 0);
        chk_idle("loop_stop");
        exp_q.delete();

        // Stop in P1 while Count=1
        push_s1(5);
`ifdef MOD_SEQ_PAUSE_EN
        repeat (4) push(1, 1, 0, 0);
`endif
        start_seq();
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
`ifdef MOD_SEQ_PAUSE_EN
        chk("pause_busy", int'(busy), 1);
        chk("pause_count", int'(count), 1);
        tick();
        start_seq();
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
`endif
        chk("stop_queue", exp_q.size(), 0);
        chk_idle("stop");
        chk("stop_flags", int'({pd, sd}), 0);
        exp_q.delete();

        // Table write while busy is dropped
        push_s1(15);
        start_seq();
        tick();
        wr(0, 7, 0);
        drain(40);
        push_s1(15);
        start_seq();
        drain(40);
        chk_idle("wr_block");

        // Async reset mid-phase, then default table
        push_s1(4);
        start_seq();
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_phase", int'(phase), 0);
        chk("arst_flags", int'({pd, sd}), 0);
        chk("arst_queue", exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_mod0();
        start_seq();
        drain(80);
        chk_idle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
